timer_ctrl_fsm: RTL

// - Control front end for the digital timer. Drives timer_pause/timer_clear into the 0-9 tick counter chain.
// - Converts raw start/stop and reset buttons into a run/pause/clear state machine.
// - Has a synchroniser and debouncer on each button, and emits one-cycle press events.
//

---
 rtl/timer_ctrl_fsm.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/timer_ctrl_fsm.sv
// Timer control front end: per-button 2-flop synchroniser, debouncer and
// press-pulse generator feeding a run/pause/clear Moore FSM.
// Optional feature: define LAP_HOLD_EN to add btn_lap / lap_hold.
module timer_ctrl_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CLEAR_CYCLES    = 1
) (
    input  logic sys_clk,
    input  logic int_reset_b,
    input  logic btn_start_stop,
    input  logic btn_reset,
`ifdef LAP_HOLD_EN
    input  logic btn_lap,
    output logic lap_hold,
`endif
    output logic timer_pause,
    output logic timer_clear,
    output logic timer_running
);

    // Button slots: 0 = start/stop, 1 = reset, 2 = lap (when enabled)
`ifdef LAP_HOLD_EN
    localparam int unsigned NBtn = 3;
`else
    localparam int unsigned NBtn = 2;
`endif

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ClW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ClW-1:0] ClLast = ClW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StClear} state_e;

    logic [NBtn-1:0] btn_raw;
    logic [NBtn-1:0] s1_q, s2_q, db_q, press_q;
    logic [DbW-1:0]  db_cnt_q [NBtn];

    state_e         state_q, state_d;
    logic [ClW-1:0] clr_cnt_q, clr_cnt_d;
    logic           pause_q, clear_q, running_q;
    logic           lap_q, lap_d;

`ifdef LAP_HOLD_EN
    assign btn_raw = {btn_lap, btn_reset, btn_start_stop};
`else
    assign btn_raw = {btn_reset, btn_start_stop};
`endif

    // Synchronise, debounce and emit a one-cycle pulse on each debounced rise
    always_ff @(posedge sys_clk) begin
        if (!int_reset_b) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < int'(NBtn); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            press_q <= '0;
            for (int i = 0; i < int'(NBtn); i++) begin
                if (s2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_q[i]     <= ~db_q[i];
                    press_q[i]  <= ~db_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Next-state logic; reset press outranks start and lap presses
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        lap_d     = lap_q;
        unique case (state_q)
            StClear: begin
                // Presses are discarded here; the pulses simply expire
                if (clr_cnt_q == ClLast) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ClW'(1);
                end
            end
            default: begin
                if (press_q[1]) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    lap_d     = 1'b0;
                end else begin
`ifdef LAP_HOLD_EN
                    if (press_q[2] && (state_q == StRun || state_q == StPaused)) begin
                        lap_d = ~lap_q;
                    end
`endif
                    if (press_q[0]) begin
                        state_d = (state_q == StRun) ? StPaused : StRun;
                    end
                end
            end
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge sys_clk) begin
        if (!int_reset_b) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
            lap_q     <= 1'b0;
            pause_q   <= 1'b1;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            lap_q     <= lap_d;
            pause_q   <= (state_d == StIdle) || (state_d == StPaused);
            clear_q   <= (state_d == StClear);
            running_q <= (state_d == StRun);
        end
    end

    assign timer_pause   = pause_q;
    assign timer_clear   = clear_q;
    assign timer_running = running_q;
`ifdef LAP_HOLD_EN
    assign lap_hold      = lap_q;
`else
    logic unused_lap;
    assign unused_lap = lap_q;
`endif

endmodule
